// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: one req/ack memory transaction per load/store,
// load-data alignment, extension select for the mask stage and pipeline stall.
module dmem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] load_data,
  output logic [2:0]  mask_sel,
  output logic [1:0]  err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t      state_r;
  logic [31:0] cnt_r;
  logic [1:0]  off_r;
  logic [2:0]  f3_r;
  logic        is_load_r;
  logic        op_s;
  logic        legal_s;
  logic        misal_s;

  function automatic logic legal_f(input logic is_load, input logic [2:0] f3);
    logic ok;
    if (is_load) begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
        default:                                ok = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010: ok = 1'b1;
        default:                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [3:0] be_f(input logic is_store, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic [3:0] be;
    if (is_store) begin
      case (f3[1:0])
        2'b00:   be = 4'b0001 << off;
        2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  function automatic logic [31:0] wdata_f(input logic is_store, input logic [2:0] f3,
                                          input logic [31:0] wd);
    logic [31:0] d;
    if (is_store) begin
      case (f3[1:0])
        2'b00:   d = {4{wd[7:0]}};
        2'b01:   d = {2{wd[15:0]}};
        default: d = wd;
      endcase
    end else begin
      d = 32'd0;
    end
    return d;
  endfunction

  // funct3 to extension select understood by the mask stage
  function automatic logic [2:0] mask_f(input logic [2:0] f3);
    logic [2:0] m;
    case (f3)
      3'b000:  m = 3'b011;
      3'b001:  m = 3'b001;
      3'b100:  m = 3'b100;
      3'b101:  m = 3'b010;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  // Decode of the op currently offered by EX/MEM
  always_comb begin
    op_s    = in_valid & (in_load | in_store);
    legal_s = legal_f(in_load, in_funct3);
    misal_s = ((in_funct3[1:0] == 2'b10) & (in_addr[1:0] != 2'b00)) |
              ((in_funct3[1:0] == 2'b01) & in_addr[0]);
  end

  assign stall = (state_r == REQ) | ((state_r == IDLE) & op_s);

  // Transaction FSM with registered memory-side and completion outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 32'd0;
      off_r      <= 2'b00;
      f3_r       <= 3'b000;
      is_load_r  <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_be    <= 4'b0000;
      dmem_wdata <= 32'd0;
      out_valid  <= 1'b0;
      load_data  <= 32'd0;
      mask_sel   <= 3'b000;
      err        <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          out_valid <= 1'b0;
          load_data <= 32'd0;
          mask_sel  <= 3'b000;
          err       <= 2'b00;
          if (op_s) begin
            off_r     <= in_addr[1:0];
            f3_r      <= in_funct3;
            is_load_r <= in_load;
            if (!legal_s) begin
              state_r   <= RESP;
              out_valid <= 1'b1;
              err       <= 2'b11;
            end else if (misal_s) begin
              state_r   <= RESP;
              out_valid <= 1'b1;
              err       <= 2'b01;
            end else begin
              state_r    <= REQ;
              cnt_r      <= 32'd0;
              dmem_req   <= 1'b1;
              dmem_we    <= in_store;
              dmem_addr  <= {in_addr[31:2], 2'b00};
              dmem_be    <= be_f(in_store, in_funct3, in_addr[1:0]);
              dmem_wdata <= wdata_f(in_store, in_funct3, in_wdata);
            end
          end
        end
        REQ: begin
          // An ack always beats a timeout landing in the same cycle
          if (dmem_ack || ((TIMEOUT_CYCLES != 32'd0) && (cnt_r == TIMEOUT_CYCLES))) begin
            state_r    <= RESP;
            out_valid  <= 1'b1;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= 32'd0;
            if (dmem_ack) begin
              err       <= 2'b00;
              load_data <= is_load_r ? (dmem_rdata >> {off_r, 3'b000}) : 32'd0;
              mask_sel  <= is_load_r ? mask_f(f3_r) : 3'b000;
            end else begin
              err       <= 2'b10;
              load_data <= 32'd0;
              mask_sel  <= 3'b000;
            end
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        RESP: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          load_data <= 32'd0;
          mask_sel  <= 3'b000;
          err       <= 2'b00;
        end
        default: begin
          state_r  <= IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: directed ops push expected completions,
// a negedge monitor pops and compares on every out_valid.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_load, in_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall, out_valid;
  logic [31:0] load_data;
  logic [2:0]  mask_sel;
  logic [1:0]  err;

  always #5 clk = ~clk;

  dmem_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_load(in_load),
    .in_store(in_store), .in_funct3(in_funct3), .in_addr(in_addr),
    .in_wdata(in_wdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
    .out_valid(out_valid), .load_data(load_data), .mask_sel(mask_sel), .err(err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  msel;
    logic [1:0]  err;
  } resp_t;

  resp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Completion monitor
  always @(negedge clk) begin : mon
    resp_t e;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("load_data", load_data, e.data);
        chk("mask_sel", {29'd0, mask_sel}, {29'd0, e.msel});
        chk("err", {30'd0, err}, {30'd0, e.err});
      end
    end
  end

  // One op; called and returns at posedge+1; req_cycles=0 means no memory access expected
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int req_cycles, input int ack_at,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_data, input logic [2:0] exp_msel,
                        input logic [1:0] exp_err);
    resp_t r;
    r.data = exp_data; r.msel = exp_msel; r.err = exp_err;
    exp_q.push_back(r);
    in_valid = 1'b1; in_load = ld; in_store = st;
    in_funct3 = f3; in_addr = addr; in_wdata = wd;
    @(negedge clk);
    chk("idle_stall", {31'd0, stall}, 32'd1);
    chk("idle_req", {31'd0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    for (int n = 1; n <= req_cycles; n++) begin
      dmem_ack = (n == ack_at);
      dmem_rdata = rd;
      @(negedge clk);
      chk("req", {31'd0, dmem_req}, 32'd1);
      chk("req_stall", {31'd0, stall}, 32'd1);
      chk("req_addr", dmem_addr, {addr[31:2], 2'b00});
      chk("req_we", {31'd0, dmem_we}, {31'd0, st});
      chk("req_be", {28'd0, dmem_be}, {28'd0, exp_be});
      if (st) chk("req_wdata", dmem_wdata, exp_wd);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      dmem_rdata = 32'd0;
    end
    @(negedge clk);
    chk("resp_valid", {31'd0, out_valid}, 32'd1);
    chk("resp_stall", {31'd0, stall}, 32'd0);
    chk("resp_req", {31'd0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
    in_funct3 = 3'b000; in_addr = 32'd0; in_wdata = 32'd0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_outs", {dmem_be, mask_sel, err, dmem_we}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ld st f3 addr wdata rdata reqcyc ackat be wdata_exp | data msel err
    run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'hAABBCCDD, 1, 1, 4'b1111, 32'h0,
           32'h000000AA, 3'b100, 2'b00);
    run_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 1, 1, 4'b1100, 32'hABCDABCD,
           32'h0, 3'b000, 2'b00);
    run_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0,
           32'h0, 3'b000, 2'b01);
    run_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h55667788, 5, 0, 4'b1111, 32'h0,
           32'h0, 3'b000, 2'b10);
    run_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h55667788, 5, 5, 4'b1111, 32'h0,
           32'h00005566, 3'b001, 2'b00);
    run_op(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0,
           32'h0, 3'b000, 2'b11);
    run_op(1'b0, 1'b1, 3'b000, 32'h301, 32'hDEADBEEF, 32'h0, 2, 2, 4'b0010, 32'hEFEFEFEF,
           32'h0, 3'b000, 2'b00);
    run_op(1'b0, 1'b1, 3'b010, 32'h400, 32'h01234567, 32'h0, 1, 1, 4'b1111, 32'h01234567,
           32'h0, 3'b000, 2'b00);
    run_op(1'b1, 1'b0, 3'b000, 32'h502, 32'h0, 32'h11223344, 3, 3, 4'b1111, 32'h0,
           32'h00001122, 3'b011, 2'b00);
    run_op(1'b1, 1'b0, 3'b101, 32'h600, 32'h0, 32'hCAFEF00D, 1, 1, 4'b1111, 32'h0,
           32'hCAFEF00D, 3'b010, 2'b00);
    run_op(1'b0, 1'b1, 3'b001, 32'h203, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0,
           32'h0, 3'b000, 2'b01);
    run_op(1'b0, 1'b1, 3'b100, 32'h200, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0,
           32'h0, 3'b000, 2'b11);

    // Non-op in_valid: nothing happens
    in_valid = 1'b1;
    @(negedge clk);
    chk("nonop_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("nonop_req", {31'd0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Reset during REQ, then a late ack
    in_valid = 1'b1; in_load = 1'b1; in_funct3 = 3'b010; in_addr = 32'h700;
    @(posedge clk); #1;
    in_valid = 1'b0; in_load = 1'b0;
    @(negedge clk);
    chk("mid_req", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", {31'd0, dmem_req}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_addr", dmem_addr, 32'd0);
    chk("mid_rst_outs", {dmem_be, mask_sel, err, dmem_we, out_valid}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_req", {31'd0, dmem_req}, 32'd0);
    chk("late_ack_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
